// File: rtl/ecg_afe_sequencer.sv
// MAX30003 sequencer: ROM-driven init, STATUS polling, ECG FIFO burst drain. `define RTOR_EN enables R-R reads.
// One SPI transaction outstanding; a stalled spi_done trips the timeout into ERR. Samples strobe the cycle after spi_done.
module ecg_afe_sequencer #(
    parameter int INIT_LEN  = 6,
    parameter int RST_DLY   = 10_000_000,
    parameter int CFG_DLY   = 5_000_000,
    parameter int POLL_CYC  = 1000,
    parameter int MAX_BURST = 32,
    parameter int TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_init,
    output logic [3:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic        spi_start,
    output logic [31:0] spi_tx,
    input  logic [31:0] spi_rx,
    input  logic        spi_done,
    output logic        init_done,
    output logic        err,
    output logic [17:0] ecg_data,
    output logic        ecg_eof,
    output logic        ecg_valid,
    output logic [13:0] rr_interval,
    output logic        rr_valid,
    output logic [7:0]  ovf_count
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int BR_W = $clog2(MAX_BURST + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_X, S_INIT_D, S_SYNC, S_POLL,
        S_STAT, S_ECG, S_FRST, S_RR, S_ERR
    } state_t;

    state_t            state, state_nx;
    logic              busy;
    logic [TO_W-1:0]   to_cnt;
    logic [31:0]       dly_cnt;
    logic [31:0]       poll_cnt;
    logic [BR_W-1:0]   burst;
    logic [31:0]       tx_word;
    logic              xfer, issue, xdone, tmo;
    logic [2:0]        etag;
    logic              ecg_take, ecg_end, rr_go;
    logic              unused_rx;

    assign unused_rx = ^{spi_rx[31:24], spi_rx[2:0]};
    assign etag      = spi_rx[5:3];

`ifdef RTOR_EN
    logic rr_pend;
    assign rr_go = rr_pend;
`else
    assign rr_go       = 1'b0;
    assign rr_interval = '0;
    assign rr_valid    = 1'b0;
`endif

    // Output/decode process: transaction word per state and completion qualifiers
    always_comb begin
        tx_word = 32'h0;
        xfer    = 1'b0;
        case (state)
            S_INIT_X: begin tx_word = rom_data;     xfer = 1'b1; end
            S_SYNC:   begin tx_word = 32'h12000000; xfer = 1'b1; end
            S_STAT:   begin tx_word = 32'h03000000; xfer = 1'b1; end
            S_ECG:    begin tx_word = 32'h43FFFFFF; xfer = 1'b1; end
            S_FRST:   begin tx_word = 32'h14000000; xfer = 1'b1; end
`ifdef RTOR_EN
            S_RR:     begin tx_word = 32'h4BFFFFFF; xfer = 1'b1; end
`endif
            default:  ;
        endcase
        issue    = xfer && !busy;
        xdone    = busy && spi_done;
        tmo      = busy && !spi_done && (to_cnt == TO_W'(TIMEOUT - 1));
        ecg_take = (etag == 3'b000) || (etag == 3'b010);
        ecg_end  = (etag == 3'b110) || (etag == 3'b010) || (burst == BR_W'(MAX_BURST - 1));
    end

    always_comb begin
        state_nx = state;
        if (tmo) begin
            state_nx = S_ERR;
        end else begin
            case (state)
                S_IDLE, S_ERR: if (start_init) state_nx = S_INIT_X;
                S_INIT_X: if (xdone) state_nx = S_INIT_D;
                S_INIT_D: if (dly_cnt == 32'd0)
                              state_nx = (rom_addr == 4'(INIT_LEN - 1)) ? S_SYNC : S_INIT_X;
                S_SYNC:   if (xdone) state_nx = S_POLL;
                S_POLL:   if (poll_cnt == 32'd0) state_nx = S_STAT;
                S_STAT: if (xdone) begin
                    if (spi_rx[23]) state_nx = S_ECG;
`ifdef RTOR_EN
                    else if (spi_rx[10]) state_nx = S_RR;
`endif
                    else state_nx = S_POLL;
                end
                S_ECG: if (xdone) begin
                    if (etag == 3'b111) state_nx = S_FRST;
                    else if (ecg_end)   state_nx = rr_go ? S_RR : S_POLL;
                end
                S_FRST: if (xdone) state_nx = S_POLL;
`ifdef RTOR_EN
                S_RR:   if (xdone) state_nx = S_POLL;
`endif
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            to_cnt    <= '0;
            dly_cnt   <= '0;
            poll_cnt  <= '0;
            burst     <= '0;
            rom_addr  <= '0;
            spi_start <= 1'b0;
            spi_tx    <= '0;
            init_done <= 1'b0;
            err       <= 1'b0;
            ecg_data  <= '0;
            ecg_eof   <= 1'b0;
            ecg_valid <= 1'b0;
            ovf_count <= '0;
`ifdef RTOR_EN
            rr_pend     <= 1'b0;
            rr_interval <= '0;
            rr_valid    <= 1'b0;
`endif
        end else begin
            spi_start <= 1'b0;
            ecg_valid <= 1'b0;
`ifdef RTOR_EN
            rr_valid  <= 1'b0;
`endif
            if (issue) begin
                spi_start <= 1'b1;
                spi_tx    <= tx_word;
                busy      <= 1'b1;
                to_cnt    <= '0;
            end else if (busy) begin
                if (spi_done || tmo) busy <= 1'b0;
                else                 to_cnt <= to_cnt + 1'b1;
            end
            if (tmo) begin
                err       <= 1'b1;
                init_done <= 1'b0;
            end
            case (state)
                S_IDLE, S_ERR: if (start_init) begin
                    rom_addr <= '0;
                    err      <= 1'b0;
`ifdef RTOR_EN
                    rr_pend  <= 1'b0;
`endif
                end
                S_INIT_X: if (xdone)
                    dly_cnt <= (rom_addr == 4'd0) ? 32'(RST_DLY) : 32'(CFG_DLY);
                S_INIT_D: begin
                    if (dly_cnt == 32'd0) rom_addr <= rom_addr + 4'd1;
                    else                  dly_cnt  <= dly_cnt - 32'd1;
                end
                S_SYNC: if (xdone) begin
                    init_done <= 1'b1;
                    poll_cnt  <= 32'(POLL_CYC);
                end
                S_POLL: if (poll_cnt != 32'd0) poll_cnt <= poll_cnt - 32'd1;
                S_STAT: if (xdone) begin
                    burst    <= '0;
                    poll_cnt <= 32'(POLL_CYC);
`ifdef RTOR_EN
                    rr_pend  <= spi_rx[23] && spi_rx[10];
`endif
                end
                S_ECG: if (xdone) begin
                    burst    <= burst + 1'b1;
                    poll_cnt <= 32'(POLL_CYC);
                    if (ecg_take) begin
                        ecg_data  <= spi_rx[23:6];
                        ecg_eof   <= (etag == 3'b010);
                        ecg_valid <= 1'b1;
                    end
                    if (etag == 3'b111 && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
                end
                S_FRST: if (xdone) poll_cnt <= 32'(POLL_CYC);
`ifdef RTOR_EN
                S_RR: if (xdone) begin
                    rr_interval <= spi_rx[23:10];
                    rr_valid    <= 1'b1;
                    rr_pend     <= 1'b0;
                    poll_cnt    <= 32'(POLL_CYC);
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
